// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_byte
// Description : 8N1 UART receiver (LSB first, idle high). Recovers each byte
//               from the serial line and presents it on a parallel bus with a
//               level valid/ack handshake. Flags bad stop bits and bytes
//               dropped while the consumer still holds an unacknowledged byte.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 2320
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    // Start-bit mid-sample offset; derived from the bit period, never overridden.
    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    // Baud counter only has to reach CLKS_PER_BIT-1.
    localparam int CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] c_half_last = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_sync1;
    logic             r_sync2;
    logic             w_rx_s;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data_out;
    logic             r_data_valid;
    logic             r_frame_err;
    logic             r_overrun;
    logic             w_shift_en;
    logic             w_good_byte;
    logic             w_bad_stop;
    logic             w_cnt_clr;

    assign w_rx_s = r_sync2;

    // Two-flop synchronizer for the asynchronous serial line; resets to idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus the per-cycle sample strobes that drive the datapath.
    always_comb begin
        w_next_state = r_state;
        w_shift_en   = 1'b0;
        w_good_byte  = 1'b0;
        w_bad_stop   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_next_state = S_START;
                end
            end
            S_START: begin
                // Mid-start-bit check: a line that has gone high again was a glitch.
                if (r_cnt == c_half_last) begin
                    w_next_state = w_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == c_bit_last) begin
                    w_shift_en = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_next_state = S_STOP;
                    end
                end
            end
            S_STOP: begin
                // Leave at the stop-bit centre so a zero-gap next start bit is caught.
                if (r_cnt == c_bit_last) begin
                    if (w_rx_s) begin
                        w_good_byte  = 1'b1;
                        w_next_state = S_IDLE;
                    end else begin
                        w_bad_stop   = 1'b1;
                        w_next_state = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                // A held-low (break) line must not look like a stream of start bits.
                if (w_rx_s) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Counter restarts on every state change and at every data-bit sample;
    // it is parked at zero in the states that do not time anything.
    assign w_cnt_clr = (w_next_state != r_state) || w_shift_en ||
                       (r_state == S_IDLE) || (r_state == S_WAIT_IDLE);

    // Baud counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Bit index and shift register; new bit enters the MSB so the LSB lands in bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            if (r_state == S_START) begin
                r_bit_idx <= 3'd0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_shift_en) begin
                r_shift <= {w_rx_s, r_shift[7:1]};
            end
        end
    end

    // Output handshake: load on a good byte when the slot is free or being
    // acknowledged this cycle, otherwise report an overrun and keep the old byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out   <= 8'h00;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_err <= w_bad_stop;
            r_overrun   <= w_good_byte && r_data_valid && !data_ack;
            if (w_good_byte && (!r_data_valid || data_ack)) begin
                r_data_out   <= r_shift;
                r_data_valid <= 1'b1;
            end else if (r_data_valid && data_ack) begin
                r_data_valid <= 1'b0;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_byte
// Description : Self-checking bench for uart_rx_byte: frame vectors, corner
//               sequences and random byte streams against a byte-queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_byte;

    localparam int CLKS = 16;
    // Pin-to-valid latency: half bit + 9 bits + 1 load cycle + 2 synchronizer cycles.
    localparam int LAT  = CLKS / 2 + 9 * CLKS + 1 + 2;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        logic [7:0] data;
        logic       stop_b;
        int         exp_bytes;
        int         exp_ferr;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ack;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int         checks;
    int         failures;
    int         cyc;

    logic [7:0] q_got[$];
    int         q_rise[$];
    int         q_start[$];
    int         q_runs[$];
    int         ferr_cnt;
    int         ovr_cnt;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ack   (data_ack),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running cycle number of the most recent rising edge.
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Observe outputs mid-cycle: valid rises, valid run lengths, consumed bytes, pulses.
    initial begin
        logic prev_valid;
        int   vrun;
        prev_valid = 1'b0;
        vrun       = 0;
        ferr_cnt   = 0;
        ovr_cnt    = 0;
        forever begin
            @(negedge clk);
            if (data_valid && !prev_valid) q_rise.push_back(cyc);
            if (data_valid) begin
                vrun++;
            end else if (prev_valid) begin
                q_runs.push_back(vrun);
                vrun = 0;
            end
            if (data_valid && data_ack) q_got.push_back(data_out);
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            prev_valid = data_valid;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic clear_obs();
        q_got.delete();
        q_rise.delete();
        q_start.delete();
        q_runs.delete();
    endtask

    // Called one time unit after a rising edge; every bit lasts exactly CLKS cycles.
    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        logic [9:0] bits;
        bits = {stop_b, d, 1'b0};
        q_start.push_back(cyc);
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (CLKS) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Compare observed stream against the model: bytes in order, fixed latency,
    // and (with ack held high) one-cycle valid per byte.
    task automatic compare_stream(input string tag, input byte_q_t exp, input bit ack_held);
        chk({tag, "_count"}, q_got.size(), exp.size());
        chk({tag, "_rises"}, q_rise.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < q_got.size()) chk({tag, "_byte"}, int'(q_got[i]), int'(exp[i]));
            if (i < q_rise.size() && i < q_start.size())
                chk({tag, "_latency"}, q_rise[i] - q_start[i], LAT);
            if (ack_held && i < q_runs.size()) chk({tag, "_valid_len"}, q_runs[i], 1);
        end
    endtask

    initial begin
        vec_t    vecs[6];
        byte_q_t exp;
        int      f0;
        int      o0;

        checks   = 0;
        failures = 0;

        vecs[0] = '{8'h00, 1'b1, 1, 0};
        vecs[1] = '{8'hFF, 1'b1, 1, 0};
        vecs[2] = '{8'hA5, 1'b1, 1, 0};
        vecs[3] = '{8'h3C, 1'b0, 0, 1};
        vecs[4] = '{8'h80, 1'b1, 1, 0};
        vecs[5] = '{8'h01, 1'b0, 0, 1};

        // Reset state
        rst_n    = 1'b0;
        rx       = 1'b1;
        data_ack = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_data_valid", int'(data_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_overrun", int'(overrun), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);

        // Single byte, no ack: exact latency and held valid
        clear_obs();
        send_frame(8'h41, 1'b1);
        idle(CLKS);
        chk("t1_rises", q_rise.size(), 1);
        if (q_rise.size() > 0) chk("t1_latency", q_rise[0] - q_start[0], LAT);
        chk("t1_data_out", int'(data_out), 8'h41);
        chk("t1_valid_held", int'(data_valid), 1);
        chk("t1_frame_err", ferr_cnt, 0);
        chk("t1_overrun", ovr_cnt, 0);
        data_ack = 1'b1;
        @(posedge clk);
        #1;
        data_ack = 1'b0;
        @(negedge clk);
        chk("t1_valid_cleared", int'(data_valid), 0);
        idle(2);

        // Back-to-back frames with ack held high
        data_ack = 1'b1;
        clear_obs();
        exp.delete();
        for (int i = 0; i < 8; i++) begin
            send_frame(8'h41 + 8'(i), 1'b1);
            exp.push_back(8'h41 + 8'(i));
        end
        idle(2 * CLKS);
        compare_stream("b2b", exp, 1'b1);
        chk("b2b_frame_err", ferr_cnt, 0);
        chk("b2b_overrun", ovr_cnt, 0);

        // Table-driven single frames
        foreach (vecs[k]) begin
            clear_obs();
            f0 = ferr_cnt;
            send_frame(vecs[k].data, vecs[k].stop_b);
            idle(2 * CLKS);
            chk("vec_bytes", q_got.size(), vecs[k].exp_bytes);
            if (vecs[k].exp_bytes == 1 && q_got.size() == 1) begin
                chk("vec_data", int'(q_got[0]), int'(vecs[k].data));
                if (q_rise.size() == 1) chk("vec_latency", q_rise[0] - q_start[0], LAT);
            end
            chk("vec_frame_err", ferr_cnt - f0, vecs[k].exp_ferr);
            chk("vec_busy_idle", int'(busy), 0);
        end

        // Overrun: two bytes without ack
        data_ack = 1'b0;
        clear_obs();
        o0 = ovr_cnt;
        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
        idle(CLKS);
        chk("ovr_data_out", int'(data_out), 8'h55);
        chk("ovr_valid", int'(data_valid), 1);
        chk("ovr_pulses", ovr_cnt - o0, 1);
        chk("ovr_rises", q_rise.size(), 1);
        data_ack = 1'b1;
        @(posedge clk);
        #1;
        data_ack = 1'b0;
        @(negedge clk);
        chk("ovr_valid_cleared", int'(data_valid), 0);
        chk("ovr_consumed", q_got.size(), 1);
        if (q_got.size() > 0) chk("ovr_consumed_byte", int'(q_got[0]), 8'h55);
        data_ack = 1'b1;
        idle(2);

        // Break: bad stop bit then line held low
        clear_obs();
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        rx = 1'b0;
        repeat (39 * CLKS) @(posedge clk);
        #1;
        @(negedge clk);
        chk("brk_busy_low", int'(busy), 1);
        chk("brk_frame_err", ferr_cnt - f0, 1);
        chk("brk_valid", int'(data_valid), 0);
        chk("brk_bytes", q_got.size(), 0);
        idle(6);
        @(negedge clk);
        chk("brk_busy_released", int'(busy), 0);
        clear_obs();
        exp.delete();
        exp.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        idle(2 * CLKS);
        compare_stream("brk_next", exp, 1'b1);

        // Short glitch in idle
        clear_obs();
        f0 = ferr_cnt;
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rx = 1'b1;
        @(negedge clk);
        chk("glitch_busy_seen", int'(busy), 1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_done", int'(busy), 0);
        idle(2 * CLKS);
        chk("glitch_rises", q_rise.size(), 0);
        chk("glitch_frame_err", ferr_cnt - f0, 0);

        // Reset during data bit 4
        clear_obs();
        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (5 * CLKS + CLKS / 2) @(posedge clk);
                #3;
                rst_n = 1'b0;
                #1;
                chk("mrst_data_out", int'(data_out), 0);
                chk("mrst_valid", int'(data_valid), 0);
                chk("mrst_busy", int'(busy), 0);
                chk("mrst_frame_err", int'(frame_err), 0);
                chk("mrst_overrun", int'(overrun), 0);
                repeat (20) @(posedge clk);
                #3;
                rst_n = 1'b1;
            end
        join
        idle(2 * CLKS);
        chk("mrst_no_byte", q_rise.size(), 0);
        clear_obs();
        exp.delete();
        exp.push_back(8'h0F);
        send_frame(8'h0F, 1'b1);
        idle(2 * CLKS);
        compare_stream("mrst_next", exp, 1'b1);

        // Random bytes with random idle gaps; model is the ordered byte queue
        clear_obs();
        exp.delete();
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        for (int i = 0; i < 12; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            idle($urandom_range(0, 40));
            send_frame(b, 1'b1);
            exp.push_back(b);
        end
        idle(2 * CLKS);
        compare_stream("rand", exp, 1'b1);
        chk("rand_frame_err", ferr_cnt - f0, 0);
        chk("rand_overrun", ovr_cnt - o0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
